if_fetch_unit: RTL and testbench

//  Instruction fetch front-end: initiator side of the instruction-memory read port.

---
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: holds the fetch PC, reads a combinational IMEM
// every cycle, buffers {pc, inst, fault} in a small prefetch FIFO and hands the
// head entry to decode over a valid/ready handshake. A redirect reloads the
// fetch PC and flushes everything still buffered.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]      fpc_q, fpc_d;
  logic             fault_pend_q, fault_pend_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q    [FIFO_DEPTH];
  logic [31:0]      mem_pc_d    [FIFO_DEPTH];
  logic [31:0]      mem_inst_q  [FIFO_DEPTH];
  logic [31:0]      mem_inst_d  [FIFO_DEPTH];
  logic             mem_fault_q [FIFO_DEPTH];
  logic             mem_fault_d [FIFO_DEPTH];

  logic             head_valid_s;
  logic             pop_s;
  logic             push_s;

  // Fetch address is the fetch PC itself; fpc is always word aligned.
  assign imem_addr    = fpc_q;
  assign head_valid_s = (count_q != CNT_W'(0));
  assign pop_s        = head_valid_s & if_ready;
  // Push whenever there is room, or a slot frees up this cycle; a redirect
  // suppresses the push because the word at the old fpc is on a dead path.
  assign push_s       = ~redirect_valid & ((count_q < CNT_W'(FIFO_DEPTH)) | pop_s);

  // Head outputs come straight from buffered storage; empty shows a NOP bubble.
  always_comb begin
    if_valid = head_valid_s;
    if (head_valid_s) begin
      if_pc    = mem_pc_q[rd_ptr_q];
      if_inst  = mem_inst_q[rd_ptr_q];
      if_fault = mem_fault_q[rd_ptr_q];
    end else begin
      if_pc    = 32'h0000_0000;
      if_inst  = NOP_INST;
      if_fault = 1'b0;
    end
  end

  // Next-state: redirect flushes and reloads fpc, otherwise push/pop the FIFO.
  always_comb begin
    fpc_d        = fpc_q;
    fault_pend_d = fault_pend_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_pc_d     = mem_pc_q;
    mem_inst_d   = mem_inst_q;
    mem_fault_d  = mem_fault_q;
    if (redirect_valid) begin
      // A same-cycle pop has already been consumed by decode; the rest is dropped.
      fpc_d        = {redirect_pc[31:2], 2'b00};
      fault_pend_d = |redirect_pc[1:0];
      rd_ptr_d     = PTR_W'(0);
      wr_ptr_d     = PTR_W'(0);
      count_d      = CNT_W'(0);
    end else begin
      if (push_s) begin
        mem_pc_d[wr_ptr_q]    = fpc_q;
        mem_inst_d[wr_ptr_q]  = imem_inst;
        mem_fault_d[wr_ptr_q] = fault_pend_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fpc_d                 = fpc_q + 32'd4;
        fault_pend_d          = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset clearing every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q        <= RESET_PC;
      fault_pend_q <= 1'b0;
      rd_ptr_q     <= PTR_W'(0);
      wr_ptr_q     <= PTR_W'(0);
      count_q      <= CNT_W'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= 32'h0000_0000;
        mem_inst_q[i]  <= 32'h0000_0000;
        mem_fault_q[i] <= 1'b0;
      end
    end else begin
      fpc_q        <= fpc_d;
      fault_pend_q <= fault_pend_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= mem_pc_d[i];
        mem_inst_q[i]  <= mem_inst_d[i];
        mem_fault_q[i] <= mem_fault_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a table of per-cycle vectors
// (inputs applied this cycle, outputs expected this cycle) followed by a
// randomly back-pressured stream checked against a PC-order scoreboard.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_fault       (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM model: content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction
  assign imem_inst = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_fault;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rn, input logic rv, input logic [31:0] rp, input logic rd,
                     input logic ck, input logic ev, input logic [31:0] ep, input logic ef,
                     input logic [31:0] ea);
    vec_t v;
    v.rst_n = rn; v.redir = rv; v.rpc = rp; v.rdy = rd; v.chk = ck;
    v.e_valid = ev; v.e_pc = ep; v.e_fault = ef; v.e_addr = ea;
    vq.push_back(v);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic        prev_hold;
  logic        seen;

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;

    //   rst  rdv  rpc           rdy chk val pc            flt addr
    // Reset, then streaming with if_ready=1
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h4);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        1'b0, 32'h8);
    // Back-pressure for 5 cycles at pc=8; FIFO fills, imem_addr holds at 0x10
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'hC);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'h10);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'h10);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'h10);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'h10);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,        1'b0, 32'h10);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        1'b0, 32'h14);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10,       1'b0, 32'h18);
    // Full FIFO + redirect 0x40 without pop
    add(1'b1, 1'b1, 32'h40,       1'b0, 1'b1, 1'b1, 32'h10,       1'b0, 32'h18);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h40);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h44);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 32'h48);
    // Redirect 0x80 together with a pop of the head
    add(1'b1, 1'b1, 32'h80,       1'b1, 1'b1, 1'b1, 32'h44,       1'b0, 32'h4C);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h80);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h84);
    // Misaligned redirect 0x42 -> fault on first entry only
    add(1'b1, 1'b1, 32'h42,       1'b1, 1'b1, 1'b1, 32'h84,       1'b0, 32'h88);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h40);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,       1'b1, 32'h44);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 32'h48);
    // Reset mid-stream with full FIFO
    add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 32'h4C);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    // Redirect to the top word, fpc wraps to 0
    add(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'h0,       1'b0, 32'h4);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    // Back-to-back redirects: last one wins
    add(1'b1, 1'b1, 32'h100,      1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h4);
    add(1'b1, 1'b1, 32'h200,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h200);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 32'h204);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n          = vq[i].rst_n;
      redirect_valid = vq[i].redir;
      redirect_pc    = vq[i].rpc;
      if_ready       = vq[i].rdy;
      #1;
      if (vq[i].chk) begin
        check($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vq[i].e_valid});
        check($sformatf("vec%0d if_pc", i), if_pc, vq[i].e_pc);
        check($sformatf("vec%0d if_inst", i), if_inst,
              vq[i].e_valid ? mem_word(vq[i].e_pc) : 32'h0000_0013);
        check($sformatf("vec%0d if_fault", i), {31'd0, if_fault}, {31'd0, vq[i].e_fault});
        check($sformatf("vec%0d imem_addr", i), imem_addr, vq[i].e_addr);
      end
    end

    // Randomly back-pressured stream: PCs in order, none skipped or repeated,
    // head held steady while stalled.
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = if_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stream_start: if_valid=0 after 5 cycles, required 1");
    end
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_pc   = 32'h0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) begin
        check("stream_hold if_pc", if_pc, prev_pc);
      end
      if (if_valid && if_ready) begin
        check("stream_order if_pc", if_pc, exp_pc);
        check("stream_order if_inst", if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      prev_hold = if_valid & ~if_ready;
      prev_pc   = if_pc;
    end
    checks++;
    if (exp_pc < 32'd100) begin
      failures++;
      $display("FAIL stream_throughput: consumed_bytes=%0d required>=100", exp_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
